uart_in_responder: RTL and testbench

//  Console-input responder for the core's getch path: answers each uart-in request
//  (io_uart_in_valid from SimTop) with one byte on io_uart_in_ch.

---
 rtl/uart_in_responder_if.sv | 20 ++
 rtl/uart_in_responder.sv | 126 ++++++++++++
 tb/tb_uart_in_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_in_responder_if.sv
// Host character feed and core getch request/response bundle for uart_in_responder.
// master = harness/testbench side, slave = responder side.
interface uart_in_responder_if;
    logic       host_valid;
    logic [7:0] host_ch;
    logic       host_ready;
    logic       uart_in_valid;
    logic [7:0] uart_in_ch;
    logic       uart_in_rsp;

    modport master (
        output host_valid, host_ch, uart_in_valid,
        input  host_ready, uart_in_ch, uart_in_rsp
    );

    modport slave (
        input  host_valid, host_ch, uart_in_valid,
        output host_ready, uart_in_ch, uart_in_rsp
    );
endinterface

// File: rtl/uart_in_responder.sv
// Console-input responder: buffers host characters in a FIFO and answers each core
// getch request one cycle later with the next byte, or EMPTY_CH when nothing is queued.
module uart_in_responder #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [7:0]  EMPTY_CH = 8'hFF,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    uart_in_responder_if.slave       bus,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_W-1:0]         empty_cnt_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]       ch_q, ch_d;
    logic [CNT_W-1:0] empty_cnt_q, empty_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [7:0]       mem_q [DEPTH];

    logic [AW-1:0] wr_idx, rd_idx;
    logic          fifo_empty, fifo_full;
    logic          push, pop, resp_empty;

    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Flush overrides both sides; a request in the flush cycle sees an empty FIFO.
    assign push       = bus.host_valid && !fifo_full && !flush_i;
    assign pop        = bus.uart_in_valid && !fifo_empty && !flush_i;
    assign resp_empty = bus.uart_in_valid && (fifo_empty || flush_i);

    assign bus.host_ready = !fifo_full;
    assign bus.uart_in_ch = ch_q;
    assign level_o        = wr_ptr_q - rd_ptr_q;
    assign empty_cnt_o    = empty_cnt_q;
    assign drop_cnt_o     = drop_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.uart_in_valid) state_d = RESP;
            RESP:    state_d = bus.uart_in_valid ? RESP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.uart_in_rsp = (state_q == RESP);
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ch_d        = ch_q;
        empty_cnt_d = empty_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (pop) begin
            ch_d = mem_q[rd_idx];
        end else if (resp_empty) begin
            ch_d = EMPTY_CH;
        end

        if (resp_empty && (empty_cnt_q != '1)) begin
            empty_cnt_d = empty_cnt_q + CNT_W'(1);
        end
        if (bus.host_valid && fifo_full && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ch_q        <= '0;
            empty_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ch_q        <= ch_d;
            empty_cnt_q <= empty_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_idx] <= bus.host_ch;
        end
    end

endmodule

// File: tb/tb_uart_in_responder.sv
// Directed bench for uart_in_responder: queue-based reference model compared every
// cycle, plus hand-computed literal expectations at key points.
module tb_uart_in_responder;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [4:0]  level;
    logic [31:0] empty_cnt;
    logic [31:0] drop_cnt;

    uart_in_responder_if bus ();

    uart_in_responder #(
        .DEPTH    (16),
        .EMPTY_CH (8'hFF),
        .CNT_W    (32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .bus         (bus),
        .level_o     (level),
        .empty_cnt_o (empty_cnt),
        .drop_cnt_o  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: what the outputs must be during the current cycle.
    byte unsigned m_q[$];
    logic [7:0]   m_ch;
    logic         m_rsp;
    int unsigned  m_empty_cnt;
    int unsigned  m_drop_cnt;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_q.delete();
                m_ch = 8'h00;
                m_rsp = 1'b0;
                m_empty_cnt = 0;
                m_drop_cnt = 0;
            end
            chk("model_rsp",   {31'd0, bus.uart_in_rsp}, {31'd0, m_rsp});
            chk("model_level", {27'd0, level}, m_q.size());
            chk("model_ready", {31'd0, bus.host_ready}, {31'd0, (m_q.size() < 16)});
            chk("model_empty_cnt", empty_cnt, m_empty_cnt);
            chk("model_drop_cnt",  drop_cnt, m_drop_cnt);
            chk("model_ch", {24'd0, bus.uart_in_ch}, {24'd0, m_ch});
            if (rst_n) begin
                // Inputs seen now are the ones sampled at the coming edge.
                automatic bit was_full  = (m_q.size() == 16);
                automatic bit was_empty = (m_q.size() == 0);
                if (bus.host_valid && was_full) m_drop_cnt++;
                m_rsp = bus.uart_in_valid;
                if (flush) begin
                    if (bus.uart_in_valid) begin
                        m_ch = 8'hFF;
                        m_empty_cnt++;
                    end
                    m_q.delete();
                end else begin
                    if (bus.uart_in_valid) begin
                        if (was_empty) begin
                            m_ch = 8'hFF;
                            m_empty_cnt++;
                        end else begin
                            m_ch = m_q.pop_front();
                        end
                    end
                    if (bus.host_valid && !was_full) m_q.push_back(bus.host_ch);
                end
            end
        end
    end

    // Drive for one cycle; returns 2 time units after the edge that sampled it.
    task automatic cyc(input logic hv, input logic [7:0] hc, input logic rv, input logic fl);
        bus.host_valid    = hv;
        bus.host_ch       = hc;
        bus.uart_in_valid = rv;
        flush             = fl;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int pushed;
        int reqs;
        int budget;
        int max_level;
        logic hv, rv;

        rst_n             = 1'b0;
        flush             = 1'b0;
        bus.host_valid    = 1'b0;
        bus.host_ch       = 8'h00;
        bus.uart_in_valid = 1'b0;
        @(posedge clk);
        #2;

        // 1: reset state
        chk("rst_ch",    {24'd0, bus.uart_in_ch}, 32'h0);
        chk("rst_rsp",   {31'd0, bus.uart_in_rsp}, 32'h0);
        chk("rst_ready", {31'd0, bus.host_ready}, 32'h1);
        chk("rst_level", {27'd0, level}, 32'h0);
        chk("rst_empty_cnt", empty_cnt, 32'h0);
        chk("rst_drop_cnt",  drop_cnt, 32'h0);
        rst_n = 1'b1;
        cyc(0, 8'h00, 0, 0);

        // 2: two bytes, three requests
        cyc(1, 8'h41, 0, 0);
        cyc(1, 8'h42, 0, 0);
        chk("t2_level", {27'd0, level}, 32'd2);
        cyc(0, 8'h00, 1, 0);
        chk("t2_rsp0", {31'd0, bus.uart_in_rsp}, 32'h1);
        chk("t2_ch0",  {24'd0, bus.uart_in_ch}, 32'h41);
        cyc(0, 8'h00, 0, 0);
        chk("t2_rsp_gap", {31'd0, bus.uart_in_rsp}, 32'h0);
        chk("t2_ch_hold", {24'd0, bus.uart_in_ch}, 32'h41);
        cyc(0, 8'h00, 1, 0);
        chk("t2_ch1",  {24'd0, bus.uart_in_ch}, 32'h42);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("t2_ch2",  {24'd0, bus.uart_in_ch}, 32'hFF);
        chk("t2_rsp2", {31'd0, bus.uart_in_rsp}, 32'h1);
        cyc(0, 8'h00, 0, 0);
        chk("t2_empty_cnt", empty_cnt, 32'd1);

        // 3: fill, overflow attempt, drain back-to-back
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0, 0);
        chk("t3_level_full", {27'd0, level}, 32'd16);
        chk("t3_ready_full", {31'd0, bus.host_ready}, 32'h0);
        cyc(1, 8'h99, 0, 0);
        chk("t3_drop_cnt", drop_cnt, 32'd1);
        chk("t3_level_hold", {27'd0, level}, 32'd16);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 8'h00, 1, 0);
            chk("t3_b2b_rsp", {31'd0, bus.uart_in_rsp}, 32'h1);
            chk("t3_b2b_ch",  {24'd0, bus.uart_in_ch}, 32'(8'h10 + i));
        end
        cyc(0, 8'h00, 0, 0);
        chk("t3_rsp_end", {31'd0, bus.uart_in_rsp}, 32'h0);
        chk("t3_level_end", {27'd0, level}, 32'd0);

        // 4: 40 bytes with random gaps, crossing the pointer wrap
        pushed = 0;
        reqs = 0;
        budget = 0;
        max_level = 0;
        while ((reqs < 40) && (budget < 2000)) begin
            hv = (pushed < 40) && ($urandom_range(0, 3) != 0);
            rv = (reqs < pushed) && ($urandom_range(0, 2) == 0);
            if (hv && bus.host_ready) pushed++;
            cyc(hv, 8'(8'h80 + pushed - 1), rv, 0);
            if (rv) begin
                chk("t4_order", {24'd0, bus.uart_in_ch}, 32'(8'h80 + reqs));
                reqs++;
            end
            if (int'(level) > max_level) max_level = int'(level);
            budget++;
        end
        chk("t4_done", 32'(reqs), 32'd40);
        chk("t4_level_le16", 32'(max_level <= 16), 32'd1);
        cyc(0, 8'h00, 0, 0);

        // 5: push and request together on an empty FIFO
        cyc(1, 8'h5A, 1, 0);
        chk("t5_ch_empty", {24'd0, bus.uart_in_ch}, 32'hFF);
        chk("t5_level", {27'd0, level}, 32'd1);
        cyc(0, 8'h00, 1, 0);
        chk("t5_ch_next", {24'd0, bus.uart_in_ch}, 32'h5A);
        cyc(0, 8'h00, 0, 0);

        // 6: flush with a concurrent request, then reset during a response
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
        chk("t6_level5", {27'd0, level}, 32'd5);
        cyc(0, 8'h00, 1, 1);
        chk("t6_flush_ch",  {24'd0, bus.uart_in_ch}, 32'hFF);
        chk("t6_flush_rsp", {31'd0, bus.uart_in_rsp}, 32'h1);
        chk("t6_flush_level", {27'd0, level}, 32'd0);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h33, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("t6_resp_before_rst", {31'd0, bus.uart_in_rsp}, 32'h1);
        chk("t6_ch_before_rst", {24'd0, bus.uart_in_ch}, 32'h33);
        bus.uart_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rsp_async_rst", {31'd0, bus.uart_in_rsp}, 32'h0);
        chk("t6_level_async_rst", {27'd0, level}, 32'd0);
        chk("t6_empty_cnt_rst", empty_cnt, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("t6_post_rst_ch", {24'd0, bus.uart_in_ch}, 32'hFF);
        cyc(0, 8'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
